// File: rtl/systolic_sequencer.sv
// systolic_sequencer: sequences one pass of the systolic MAC array.
// Weight load (optional) -> one-cycle accumulator clear -> diagonally skewed
// per-row r_en schedule for N vectors -> pipeline flush -> done pulse.

// One row of the skewed schedule: row ROW streams while t is in [ROW, ROW+N-1].
module systolic_sequencer_row #(
  parameter int CW  = 17,
  parameter int ROW = 0
) (
  input  logic [CW-1:0] t_i,
  input  logic [CW-1:0] n_i,
  output logic          en_o
);
  assign en_o = (t_i >= CW'(ROW)) && (t_i < n_i + CW'(ROW));
endmodule

module systolic_sequencer #(
  parameter int array_size   = 9,
  parameter int vec_w        = 16,
  parameter int flush_cycles = 2 * array_size
) (
  input  logic                  s_clk,
  input  logic                  s_reset,
  input  logic                  start,
  input  logic                  load_weights,
  input  logic [vec_w-1:0]      num_vectors,
  input  logic                  abort,
  input  logic                  w_done,
  output logic                  weight_write_enable,
  output logic                  clear,
  output logic [array_size-1:0] r_en,
  output logic                  busy,
  output logic                  done
);

  // One counter serves LOAD_W residency, RUN time t and FLUSH length; one
  // extra bit over vec_w keeps N+array_size-2 from wrapping at N=2^vec_w-1.
  localparam int FW = $clog2(flush_cycles + 1);
  localparam int CW = (vec_w + 1 > FW) ? vec_w + 1 : FW;

  typedef enum logic [2:0] {IDLE, LOAD_W, CLEAR, RUN, FLUSH, DONE} state_t;

  state_t                state_q;
  logic [vec_w-1:0]      n_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         t_d;
  logic [CW-1:0]         n_ext;
  logic [1:0]            wsync_q;
  logic [array_size-1:0] r_en_d;
  logic                  run_last;
  logic                  flush_last;

  // Schedule time of the cycle being set up: 0 on RUN entry, t+1 inside RUN.
  always_comb begin
    t_d = '0;
    if (state_q == RUN) t_d = cnt_q + CW'(1);
  end

  assign n_ext      = CW'(n_q);
  assign run_last   = (cnt_q + CW'(1)) == (n_ext + CW'(array_size - 1));
  assign flush_last = cnt_q == CW'(flush_cycles - 1);

  genvar gi;
  for (gi = 0; gi < array_size; gi++) begin : g_row
    systolic_sequencer_row #(.CW(CW), .ROW(gi)) u_row (
      .t_i  (t_d),
      .n_i  (n_ext),
      .en_o (r_en_d[gi])
    );
  end

  // Two-flop synchroniser for the loader's completion level.
  always_ff @(posedge s_clk) begin
    if (s_reset) wsync_q <= '0;
    else         wsync_q <= {wsync_q[0], w_done};
  end

  // Pass FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge s_clk) begin
    if (s_reset) begin
      state_q             <= IDLE;
      n_q                 <= '0;
      cnt_q               <= '0;
      weight_write_enable <= 1'b0;
      clear               <= 1'b1;
      r_en                <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q             <= IDLE;
      cnt_q               <= '0;
      weight_write_enable <= 1'b0;
      clear               <= 1'b1;
      r_en                <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            n_q   <= num_vectors;
            cnt_q <= '0;
            busy  <= 1'b1;
            if (num_vectors == '0) begin
              state_q <= DONE;
              done    <= 1'b1;
            end else if (load_weights) begin
              state_q             <= LOAD_W;
              weight_write_enable <= 1'b1;
            end else begin
              state_q <= CLEAR;
              clear   <= 1'b0;
            end
          end
        end
        LOAD_W: begin
          // cnt_q != 0 enforces two cycles even if w_done was already high.
          if (wsync_q[1] && cnt_q != '0) begin
            state_q             <= CLEAR;
            weight_write_enable <= 1'b0;
            clear               <= 1'b0;
          end else begin
            cnt_q <= CW'(1);
          end
        end
        CLEAR: begin
          state_q <= RUN;
          clear   <= 1'b1;
          cnt_q   <= '0;
          r_en    <= r_en_d;
        end
        RUN: begin
          if (run_last) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            r_en    <= '0;
          end else begin
            cnt_q <= t_d;
            r_en  <= r_en_d;
          end
        end
        FLUSH: begin
          if (flush_last) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: table of directed passes with hand-derived
// done cycle and total r_en activity, a reset-during-load sequence, and
// random passes, all checked cycle by cycle against a timeline model.
module tb_systolic_sequencer;
  localparam int AS = 9;
  localparam int VW = 16;
  localparam int FL = 18;

  logic          s_clk, s_reset, start, load_weights, abort, w_done;
  logic [VW-1:0] num_vectors;
  logic          weight_write_enable, clear, busy, done;
  logic [AS-1:0] r_en;

  int checks = 0;
  int errors = 0;

  systolic_sequencer #(.array_size(AS), .vec_w(VW), .flush_cycles(FL)) dut (
    .s_clk               (s_clk),
    .s_reset             (s_reset),
    .start               (start),
    .load_weights        (load_weights),
    .num_vectors         (num_vectors),
    .abort               (abort),
    .w_done              (w_done),
    .weight_write_enable (weight_write_enable),
    .clear               (clear),
    .r_en                (r_en),
    .busy                (busy),
    .done                (done)
  );

  initial s_clk = 1'b0;
  always #5 s_clk = ~s_clk;

  typedef struct {
    logic          wwe;
    logic          clr;
    logic [AS-1:0] ren;
    logic          busy;
    logic          done;
  } exp_t;

  typedef struct {
    bit lw;
    int n;
    int wd;        // cycle w_done rises (negative: before start)
    int ab;        // abort cycle, 0 = none
    int rs;        // cycle of an extra start, 0 = none
    int rs_n;
    int exp_done;  // cycle done is seen, 0 = never
    int exp_ones;  // total r_en bits set over the pass
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, " wwe"},   32'(weight_write_enable), 32'(e.wwe));
    chk({tag, " clear"}, 32'(clear),               32'(e.clr));
    chk({tag, " r_en"},  32'(r_en),                32'(e.ren));
    chk({tag, " busy"},  32'(busy),                32'(e.busy));
    chk({tag, " done"},  32'(done),                32'(e.done));
  endtask

  // Timeline of a pass, counted in cycles after the accepting edge (k=1 first).
  function automatic int calc_l(bit lw, int wd);
    if (!lw) return 0;
    return (wd + 2 > 2) ? wd + 2 : 2;
  endfunction

  function automatic int calc_d(bit lw, int n, int wd);
    if (n == 0) return 1;
    return calc_l(lw, wd) + 1 + n + AS + FL;
  endfunction

  function automatic exp_t model(int k, bit lw, int n, int wd, int ab);
    exp_t m;
    int l, c, d, t;
    m.wwe = 1'b0; m.clr = 1'b1; m.ren = '0; m.busy = 1'b0; m.done = 1'b0;
    l = calc_l(lw, wd);
    c = l + 1;
    d = calc_d(lw, n, wd);
    if (ab > 0 && k > ab) return m;
    if (k < 1 || k > d) return m;
    m.busy = 1'b1;
    if (k == d) m.done = 1'b1;
    if (n == 0) return m;
    if (k <= l) m.wwe = 1'b1;
    if (k == c) m.clr = 1'b0;
    t = k - c - 1;
    if (t >= 0 && t < n + AS - 1)
      for (int i = 0; i < AS; i++) m.ren[i] = (t >= i) && (t - i < n);
    return m;
  endfunction

  int pass_no = 0;

  // Idle cycles between passes; abort in IDLE must change nothing.
  task automatic idle_gap(input int cyc);
    exp_t idle;
    idle = model(0, 1'b0, 0, 0, 0);
    for (int i = 0; i < cyc; i++) begin
      abort = (i == 1);
      @(negedge s_clk);
      cmp_out($sformatf("idle p%0d i%0d", pass_no, i), idle);
      @(posedge s_clk); #1;
    end
    abort = 1'b0;
  endtask

  // Entered and left just after a rising edge with the DUT idle.
  task automatic run_pass(input bit lw, input int n, input int wd, input int ab,
                          input int rs, input int rs_n,
                          output int done_cyc, output int ones);
    int d, last;
    done_cyc = 0;
    ones = 0;
    pass_no++;
    if (lw && wd < 0) begin
      w_done = 1'b1;
      repeat (-wd) @(posedge s_clk);
      #1;
    end
    start = 1'b1; load_weights = lw; num_vectors = VW'(n);
    if (lw && wd == 0) w_done = 1'b1;
    @(posedge s_clk); #1;
    d = calc_d(lw, n, wd);
    last = (ab > 0 && ab <= d) ? ab + 1 : d + 1;
    for (int k = 1; k <= last; k++) begin
      if (lw && k == wd) w_done = 1'b1;
      abort = (k == ab);
      if (k == rs) begin
        start = 1'b1; num_vectors = VW'(rs_n); load_weights = ~lw;
      end else begin
        start = 1'b0; num_vectors = VW'($urandom);
      end
      @(negedge s_clk);
      cmp_out($sformatf("p%0d k%0d", pass_no, k), model(k, lw, n, wd, ab));
      if (done === 1'b1 && done_cyc == 0) done_cyc = k;
      ones += $countones(r_en);
      @(posedge s_clk); #1;
    end
    start = 1'b0; abort = 1'b0; w_done = 1'b0;
    idle_gap(3);
  endtask

  vec_t tbl[10];
  int dc, on;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{lw:0, n:4,  wd:0,  ab:0, rs:0, rs_n:0,  exp_done:32, exp_ones:36};
    tbl[1] = '{lw:1, n:20, wd:10, ab:0, rs:0, rs_n:0,  exp_done:60, exp_ones:180};
    tbl[2] = '{lw:1, n:0,  wd:0,  ab:0, rs:0, rs_n:0,  exp_done:1,  exp_ones:0};
    tbl[3] = '{lw:0, n:8,  wd:0,  ab:7, rs:0, rs_n:0,  exp_done:0,  exp_ones:21};
    tbl[4] = '{lw:0, n:8,  wd:0,  ab:0, rs:0, rs_n:0,  exp_done:36, exp_ones:72};
    tbl[5] = '{lw:0, n:5,  wd:0,  ab:0, rs:4, rs_n:30, exp_done:33, exp_ones:45};
    tbl[6] = '{lw:1, n:1,  wd:-3, ab:0, rs:0, rs_n:0,  exp_done:31, exp_ones:9};
    tbl[7] = '{lw:1, n:3,  wd:0,  ab:0, rs:2, rs_n:0,  exp_done:33, exp_ones:27};
    tbl[8] = '{lw:1, n:2,  wd:5,  ab:4, rs:0, rs_n:0,  exp_done:0,  exp_ones:0};
    tbl[9] = '{lw:0, n:12, wd:0,  ab:0, rs:0, rs_n:0,  exp_done:40, exp_ones:108};

    s_reset = 1'b1; start = 1'b0; load_weights = 1'b0; abort = 1'b0;
    w_done = 1'b0; num_vectors = '0;
    repeat (2) @(posedge s_clk);
    #1;
    @(negedge s_clk);
    cmp_out("reset", model(0, 1'b0, 0, 0, 0));
    s_reset = 1'b0;
    @(posedge s_clk); #1;
    idle_gap(2);

    for (int v = 0; v < 10; v++) begin
      run_pass(tbl[v].lw, tbl[v].n, tbl[v].wd, tbl[v].ab, tbl[v].rs, tbl[v].rs_n, dc, on);
      chk($sformatf("tbl%0d done_cycle", v), 32'(dc), 32'(tbl[v].exp_done));
      chk($sformatf("tbl%0d r_en_ones", v), 32'(on), 32'(tbl[v].exp_ones));
    end

    // Reset during LOAD_W with start held: outputs return to reset values and
    // the pass is accepted only once reset is released.
    start = 1'b1; load_weights = 1'b1; num_vectors = 16'd6;
    @(posedge s_clk); #1;
    @(negedge s_clk);
    chk("rst load wwe", 32'(weight_write_enable), 32'd1);
    @(posedge s_clk); #1;
    s_reset = 1'b1;
    @(posedge s_clk); #1;
    @(negedge s_clk);
    cmp_out("rst mid", model(0, 1'b0, 0, 0, 0));
    @(posedge s_clk); #1;
    @(negedge s_clk);
    cmp_out("rst held", model(0, 1'b0, 0, 0, 0));
    s_reset = 1'b0;
    @(posedge s_clk); #1;
    @(negedge s_clk);
    chk("rst accept busy", 32'(busy), 32'd1);
    chk("rst accept wwe", 32'(weight_write_enable), 32'd1);
    start = 1'b0; abort = 1'b1;
    @(posedge s_clk); #1;
    abort = 1'b0;
    @(negedge s_clk);
    cmp_out("rst abort", model(0, 1'b0, 0, 0, 0));
    @(posedge s_clk); #1;
    idle_gap(3);

    for (int r = 0; r < 25; r++) begin
      bit lw;
      int n, wd, d, ab, rs;
      lw = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 25));
      wd = lw ? int'($urandom_range(0, 14)) - 2 : 0;
      d  = calc_d(lw, n, wd);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, d)) : 0;
      rs = int'($urandom_range(1, d));
      run_pass(lw, n, wd, ab, rs, int'($urandom_range(0, 40)), dc, on);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
